// File: rtl/cpu_clk_ctrl.sv
// Run/step controller for the minicpu: issues one-cycle cpu_en pulses from the system clock.
// Optional burst mode is built only when CPU_CLK_CTRL_BURST_EN is defined.
module cpu_clk_ctrl #(
  parameter int unsigned           CNT_W       = 26,
  parameter logic [CNT_W-1:0]      DEFAULT_DIV = CNT_W'(49_999_999),
  parameter int unsigned           BURST_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               cpu_halt,
  input  logic               halt_clr,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_val,
  input  logic               burst_start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cpu_en,
  output logic [2:0]         mode
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    BURST  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_reg;
  logic             cpu_en_reg;
  logic             step_prev_reg;
  logic             step_edge;
  logic             tick;

  assign step_edge = step_req & ~step_prev_reg;
  assign tick      = (cnt_reg == div_reg);

`ifdef CPU_CLK_CTRL_BURST_EN
  logic               burst_prev_reg;
  logic [BURST_W-1:0] burst_rem_reg;
  logic               burst_edge;

  assign burst_edge = burst_start & ~burst_prev_reg;
`else
  logic unused_burst;
  assign unused_burst = ^{burst_start, burst_len};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      div_reg       <= DEFAULT_DIV;
      cpu_en_reg    <= 1'b0;
      step_prev_reg <= 1'b0;
`ifdef CPU_CLK_CTRL_BURST_EN
      burst_prev_reg <= 1'b0;
      burst_rem_reg  <= '0;
`endif
    end else begin
      step_prev_reg <= step_req;
`ifdef CPU_CLK_CTRL_BURST_EN
      burst_prev_reg <= burst_start;
`endif
      if (div_load)
        div_reg <= div_val;
      cpu_en_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (cpu_halt)
            state_reg <= HALTED;
          else if (run_req)
            state_reg <= RUN;
          else if (step_edge) begin
            state_reg  <= STEP;
            cpu_en_reg <= 1'b1;
          end
`ifdef CPU_CLK_CTRL_BURST_EN
          else if (burst_edge && (burst_len != '0)) begin
            state_reg     <= BURST;
            burst_rem_reg <= burst_len;
          end
`endif
        end

        STEP: begin
          cnt_reg   <= '0;
          state_reg <= cpu_halt ? HALTED : IDLE;
        end

        // Halt outranks a coincident tick; a divider load restarts the period.
        RUN: begin
          if (cpu_halt) begin
            state_reg <= HALTED;
            cnt_reg   <= '0;
          end else if (!run_req) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (div_load) begin
            cnt_reg <= '0;
          end else if (tick) begin
            cpu_en_reg <= 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

`ifdef CPU_CLK_CTRL_BURST_EN
        BURST: begin
          if (cpu_halt) begin
            state_reg <= HALTED;
            cnt_reg   <= '0;
          end else if (div_load) begin
            cnt_reg <= '0;
          end else if (tick) begin
            cpu_en_reg    <= 1'b1;
            cnt_reg       <= '0;
            burst_rem_reg <= burst_rem_reg - BURST_W'(1);
            if (burst_rem_reg == BURST_W'(1))
              state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`endif

        HALTED: begin
          cnt_reg <= '0;
          if (halt_clr && !cpu_halt)
            state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign cpu_en = cpu_en_reg;
  assign mode   = state_reg;

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run/step controller that sequences the minicpu core by issuing one-cycle `cpu_en` pulses derived from the 50 MHz system clock. It replaces a free-running divided clock with a single-clock enable scheme supporting continuous run at a programmable rate, single-step from a button, and halt on CPU request. It sits between the board inputs (switches/buttons, already synchronised to `clk`) and the CPU core's clock-enable input.

## Interface
- `CNT_W`, 26, width of rate counter and divider register
- `DEFAULT_DIV`, 26'd49_999_999, divider value after reset (1 Hz at 50 MHz)
- `BURST_W`, 8, width of burst length

- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  asynchronous, active-low reset
- `run_req`  in  1  level; 1 = continuous run requested
- `step_req`  in  1  level (button); rising edge requests one step
- `cpu_halt`  in  1  level from CPU; 1 = CPU executed halt
- `halt_clr`  in  1  level; clears HALTED state
- `div_load`  in  1  one-cycle strobe; load `div_val` into divider register
- `div_val`  in  CNT_W  new divider value
- `burst_start`  in  1  rising edge starts a burst (macro only)
- `burst_len`  in  BURST_W  pulses per burst (macro only)
- `cpu_en`  out  1  registered one-cycle CPU step enable
- `mode`  out  3  current state encoding

## Operation
- States: IDLE=0, RUN=1, STEP=2, BURST=3, HALTED=4; `mode` is the registered state.
- Edge detect: `step_req & ~step_prev`, `burst_start & ~burst_prev`; prev registers reset to 0.
- IDLE: `cpu_en`=0, `cnt`=0. Priority: `cpu_halt` -> HALTED; `run_req` -> RUN; step edge -> STEP with `cpu_en`<=1; burst edge with `burst_len`!=0 -> BURST (load `burst_rem`=`burst_len`). `burst_len`=0 ignored.
- STEP: lasts exactly one cycle; returns to IDLE, `cpu_en`<=0.
- RUN: `cnt` increments each cycle; when `cnt`==`div_reg`, `cpu_en`<=1 and `cnt`<=0, else `cpu_en`<=0. `run_req`=0 -> IDLE, `cnt` cleared, no pulse that cycle.
- BURST: same rate logic as RUN; each pulse decrements `burst_rem`; the pulse with `burst_rem`==1 returns to IDLE. `run_req` ignored in BURST.
- Any state except HALTED: `cpu_halt`=1 -> HALTED, `cpu_en`<=0, `cnt`<=0 (halt beats a coincident tick).
- HALTED: `cpu_en`=0; `halt_clr`=1 and `cpu_halt`=0 -> IDLE. Step/run/burst requests ignored.
- `div_load`: `div_reg`<=`div_val` in any state; in RUN/BURST also clears `cnt` that cycle and suppresses a coincident tick.
- `cnt` compare is unsigned, CNT_W wide; `div_reg`=0 gives `cpu_en` high every cycle in RUN.

## Timing
- Reset (async assert, sync release): `cpu_en`=0, `mode`=0, `cnt`=0, `div_reg`=DEFAULT_DIV, `burst_rem`=0, edge registers 0.
- Step latency: `step_req` sampled high (low previous cycle) at edge N -> `cpu_en` high for cycle N..N+1 only.
- RUN: first pulse `div_reg`+1 cycles after the edge that entered RUN; period `div_reg`+1 thereafter.
- Held `step_req` yields exactly one pulse; a new step needs a low sample first.
- Reset mid-burst or mid-run: state returns to IDLE immediately, no partial pulse.

## Configuration
- `CPU_CLK_CTRL_BURST_EN` defined: BURST state and `burst_rem` counter built as above.
- Not defined: `burst_start`/`burst_len` ports remain but are ignored; `mode` never equals 3; no `burst_rem` register.

## Test plan
- DEFAULT_DIV=3, `run_req`=1 from reset release -> `cpu_en` pulses on cycles 4, 8, 12; drop `run_req` -> no further pulses, `mode`=0.
- IDLE, `step_req` high for 10 cycles -> exactly one `cpu_en` pulse, one cycle after rising edge; `mode` 0->2->0.
- RUN with DIV=3, `cpu_halt` asserted on a tick cycle -> no pulse, `mode`=4; `halt_clr` with `cpu_halt`=0 -> `mode`=0.
- RUN, `div_load` with `div_val`=1 -> `cnt` cleared, pulses every 2 cycles thereafter; `div_val`=0 -> `cpu_en` continuously high.
- Macro on, DIV=2, `burst_len`=4, burst edge -> exactly 4 pulses 3 cycles apart, then `mode`=0; `burst_len`=0 -> stays IDLE.
- Async `rst` low mid-RUN -> `cpu_en`=0, `mode`=0, `div_reg`=DEFAULT_DIV immediately.
